min_distortion_selector: RTL and testbench

//  Final stage of the full-search motion estimator, directly downstream of the processing-element array.

---
 rtl/min_distortion_selector.sv | 143 ++++++++++++++
 tb/tb_min_distortion_selector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/min_distortion_selector.sv
// Tracks the minimum block distortion over a ROWS x COLS search window and reports
// the winning candidate position with a one-cycle done pulse.
module min_distortion_selector #(
    parameter int unsigned DIST_WIDTH = 8,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 16,
    parameter int unsigned COL_W      = 4,
    parameter int unsigned ROW_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dist_valid,
    input  logic [DIST_WIDTH-1:0] accumulate,
    output logic                  busy,
    output logic                  done,
    output logic [DIST_WIDTH-1:0] best_dist,
    output logic [ROW_W-1:0]      best_row,
    output logic [COL_W-1:0]      best_col
);

    typedef enum logic [1:0] {StIdle, StSearch, StReport} state_e;

    localparam logic [COL_W-1:0]      LastCol = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      LastRow = ROW_W'(ROWS - 1);
    localparam logic [DIST_WIDTH-1:0] AllOnes = '1;

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [DIST_WIDTH-1:0]   min_q, min_d;
    logic [ROW_W-1:0]        min_row_q, min_row_d;
    logic [COL_W-1:0]        min_col_q, min_col_d;
    logic [DIST_WIDTH-1:0]   best_dist_q, best_dist_d;
    logic [ROW_W-1:0]        best_row_q, best_row_d;
    logic [COL_W-1:0]        best_col_q, best_col_d;

    // Minimum including the sample currently presented, so the last candidate
    // can be folded straight into best_* on the transition into report.
    logic                    take;
    logic [DIST_WIDTH-1:0]   cand_min;
    logic [ROW_W-1:0]        cand_row;
    logic [COL_W-1:0]        cand_col;

    always_comb begin
        take     = accumulate < min_q;
        cand_min = take ? accumulate : min_q;
        cand_row = take ? row_q : min_row_q;
        cand_col = take ? col_q : min_col_q;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        min_d       = min_q;
        min_row_d   = min_row_q;
        min_col_d   = min_col_q;
        best_dist_d = best_dist_q;
        best_row_d  = best_row_q;
        best_col_d  = best_col_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSearch;
                    row_d     = '0;
                    col_d     = '0;
                    min_d     = AllOnes;
                    min_row_d = '0;
                    min_col_d = '0;
                end
            end
            StSearch: begin
                if (start) begin
                    // Abort and restart; a coincident sample is dropped.
                    row_d     = '0;
                    col_d     = '0;
                    min_d     = AllOnes;
                    min_row_d = '0;
                    min_col_d = '0;
                end else if (dist_valid) begin
                    min_d     = cand_min;
                    min_row_d = cand_row;
                    min_col_d = cand_col;
                    if (col_q == LastCol) begin
                        col_d = '0;
                        if (row_q == LastRow) begin
                            row_d       = '0;
                            state_d     = StReport;
                            best_dist_d = cand_min;
                            best_row_d  = cand_row;
                            best_col_d  = cand_col;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            min_q       <= AllOnes;
            min_row_q   <= '0;
            min_col_q   <= '0;
            best_dist_q <= '0;
            best_row_q  <= '0;
            best_col_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            min_q       <= min_d;
            min_row_q   <= min_row_d;
            min_col_q   <= min_col_d;
            best_dist_q <= best_dist_d;
            best_row_q  <= best_row_d;
            best_col_q  <= best_col_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StReport);
        best_dist = best_dist_q;
        best_row  = best_row_q;
        best_col  = best_col_q;
    end

endmodule

// File: tb/tb_min_distortion_selector.sv
// Directed bench for min_distortion_selector on a 4x4 search window.
module tb_min_distortion_selector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dist_valid = 1'b0;
    logic [7:0] accumulate = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] best_dist;
    logic [1:0] best_row;
    logic [1:0] best_col;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    logic [7:0] vals [16];

    min_distortion_selector #(
        .DIST_WIDTH (8),
        .COLS       (4),
        .ROWS       (4),
        .COL_W      (2),
        .ROW_W      (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dist_valid (dist_valid),
        .accumulate (accumulate),
        .busy       (busy),
        .done       (done),
        .best_dist  (best_dist),
        .best_row   (best_row),
        .best_col   (best_col)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        dist_valid = 1'b1;
        accumulate = v;
        tick(1);
        dist_valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) vals[i] = v;
    endtask

    // Feeds all 16 candidates with `gap` idle cycles between strobes.
    task automatic run_window(input int gap);
        for (int i = 0; i < 16; i++) begin
            strobe(vals[i]);
            if (i < 15) tick(gap);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic [1:0] r,
                                input logic [1:0] c);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_dist"}, {24'd0, best_dist}, {24'd0, d});
        check({tag, "_row"}, {30'd0, best_row}, {30'd0, r});
        check({tag, "_col"}, {30'd0, best_col}, {30'd0, c});
        tick(1);
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // 1: reset then idle
        tick(2);
        reset = 1'b0;
        tick(5);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dist", {24'd0, best_dist}, 32'd0);
        check("rst_row", {30'd0, best_row}, 32'd0);
        check("rst_col", {30'd0, best_col}, 32'd0);

        // 2: single minimum at index 9 -> (2,1)
        done_count = 0;
        fill(8'd200);
        vals[9] = 8'd3;
        do_start();
        check("t2_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 15; i++) strobe(vals[i]);
        check("t2_no_early_done", {31'd0, done}, 32'd0);
        strobe(vals[15]);
        // start during report must be ignored
        start = 1'b1;
        check_result("t2", 8'd3, 2'd2, 2'd1);
        start = 1'b0;
        check("t2_pulses", done_count, 32'd1);

        // 3: tie, first in raster order wins
        fill(8'd50);
        vals[5] = 8'd7;
        vals[12] = 8'd7;
        do_start();
        run_window(0);
        check_result("t3", 8'd7, 2'd1, 2'd1);

        // 4: all-ones window records (0,0); then last index minimum
        fill(8'hFF);
        do_start();
        run_window(0);
        check_result("t4a", 8'hFF, 2'd0, 2'd0);
        vals[15] = 8'd0;
        do_start();
        run_window(0);
        check_result("t4b", 8'd0, 2'd3, 2'd3);

        // 5: idle strobes ignored, abort with coincident sample discarded
        strobe(8'd0);
        strobe(8'd0);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_hold_dist", {24'd0, best_dist}, 32'd0);
        done_count = 0;
        do_start();
        for (int i = 0; i < 6; i++) strobe(8'd1);
        start = 1'b1;
        strobe(8'd0);
        start = 1'b0;
        check("t5_abort_busy", {31'd0, busy}, 32'd1);
        check("t5_abort_hold", {30'd0, best_row}, 32'd3);
        fill(8'd9);
        vals[4] = 8'd2;
        run_window(0);
        check_result("t5", 8'd2, 2'd1, 2'd0);
        check("t5_pulses", done_count, 32'd1);

        // 6: reset mid-search, then gapped search
        done_count = 0;
        do_start();
        for (int i = 0; i < 10; i++) strobe(8'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_cleared", {24'd0, best_dist}, 32'd0);
        check("t6_cleared_row", {30'd0, best_row}, 32'd0);
        tick(3);
        check("t6_no_done", done_count, 32'd0);
        fill(8'd100);
        vals[14] = 8'd5;
        do_start();
        run_window(2);
        check_result("t6", 8'd5, 2'd3, 2'd2);
        check("t6_pulses", done_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
